// File: rtl/fp_operand_loader_if.sv
// Byte stream carrying command and operand bytes into the FP operand loader.
interface fp_operand_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/fp_operand_loader.sv
// Assembles a command byte and two IEEE-754 singles from a byte stream, holds them for the
// FP adder and flags operand classes the adder cannot handle.
module fp_operand_loader #(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter bit          MSB_FIRST   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clear,
  fp_operand_loader_if.slave   in_if,
  output logic                 command,
  output logic [31:0]          number1,
  output logic [31:0]          number2,
  output logic                 op_valid,
  output logic                 done,
  output logic [3:0]           special
);

  typedef enum logic [2:0] {StCmd, StN1, StN2, StHold, StDone} state_e;

  localparam logic [3:0] HoldInit = 4'(HOLD_CYCLES - 1);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [3:0]  hold_q, hold_d;
  logic        sh_cmd_q, sh_cmd_d;
  logic [31:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d;
  logic        command_q, command_d;
  logic [31:0] number1_q, number1_d, number2_q, number2_d;
  logic [3:0]  special_q, special_d;
  logic        op_valid_q, op_valid_d;
  logic        done_q, done_d;
  logic        ready, accept;

  function automatic logic [31:0] load_byte(logic [31:0] cur, logic [1:0] idx, logic [7:0] b);
    logic [31:0] r;
    r = cur;
    if (MSB_FIRST) r = {cur[23:0], b};
    else           r[8*idx+:8] = b;
    return r;
  endfunction

  // {NaN, inf, denormal, zero}
  function automatic logic [3:0] classify(logic [31:0] v);
    logic exp_zero, exp_ones, man_zero;
    exp_zero = (v[30:23] == 8'h00);
    exp_ones = (v[30:23] == 8'hFF);
    man_zero = (v[22:0] == 23'd0);
    return {exp_ones & ~man_zero, exp_ones & man_zero, exp_zero & ~man_zero, exp_zero & man_zero};
  endfunction

  assign accept = in_if.in_valid & ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StCmd;
      cnt_q      <= 2'd0;
      hold_q     <= 4'd0;
      sh_cmd_q   <= 1'b0;
      sh_a_q     <= 32'd0;
      sh_b_q     <= 32'd0;
      command_q  <= 1'b0;
      number1_q  <= 32'd0;
      number2_q  <= 32'd0;
      special_q  <= 4'd0;
      op_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      sh_cmd_q   <= sh_cmd_d;
      sh_a_q     <= sh_a_d;
      sh_b_q     <= sh_b_d;
      command_q  <= command_d;
      number1_q  <= number1_d;
      number2_q  <= number2_d;
      special_q  <= special_d;
      op_valid_q <= op_valid_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    sh_cmd_d   = sh_cmd_q;
    sh_a_d     = sh_a_q;
    sh_b_d     = sh_b_q;
    command_d  = command_q;
    number1_d  = number1_q;
    number2_d  = number2_q;
    special_d  = special_q;
    op_valid_d = op_valid_q;
    done_d     = 1'b0;
    unique case (state_q)
      StCmd: if (accept) begin
        sh_cmd_d = in_if.in_data[0];
        state_d  = StN1;
      end
      StN1: if (accept) begin
        sh_a_d = load_byte(sh_a_q, cnt_q, in_if.in_data);
        cnt_d  = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = StN2;
      end
      StN2: if (accept) begin
        sh_b_d = load_byte(sh_b_q, cnt_q, in_if.in_data);
        cnt_d  = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          command_d  = sh_cmd_q;
          number1_d  = sh_a_q;
          number2_d  = sh_b_d;
          special_d  = classify(sh_a_q) | classify(sh_b_d);
          op_valid_d = 1'b1;
          hold_d     = HoldInit;
          state_d    = StHold;
        end
      end
      StHold: begin
        if (hold_q == 4'd0) begin
          state_d    = StDone;
          op_valid_d = 1'b0;
          done_d     = 1'b1;
        end else begin
          hold_d = hold_q - 4'd1;
        end
      end
      StDone:  state_d = StCmd;
      default: state_d = StCmd;
    endcase
    // Flush wins over everything, including a completing operand; presented outputs are kept.
    if (clear) begin
      state_d    = StCmd;
      cnt_d      = 2'd0;
      hold_d     = 4'd0;
      sh_cmd_d   = sh_cmd_q;
      sh_a_d     = sh_a_q;
      sh_b_d     = sh_b_q;
      command_d  = command_q;
      number1_d  = number1_q;
      number2_d  = number2_q;
      special_d  = special_q;
      op_valid_d = 1'b0;
      done_d     = 1'b0;
    end
  end

  always_comb begin
    ready    = (state_q == StCmd) || (state_q == StN1) || (state_q == StN2);
    command  = command_q;
    number1  = number1_q;
    number2  = number2_q;
    special  = special_q;
    op_valid = op_valid_q;
    done     = done_q;
  end

  assign in_if.in_ready = ready;

endmodule

// File: tb/tb_fp_operand_loader.sv
// Directed bench for fp_operand_loader: MSB-first instance with table vectors and corner
// sequences, plus an LSB-first instance fed with random gaps.
module tb_fp_operand_loader;
  logic clk, rstn, clear;
  fp_operand_loader_if m_if ();
  fp_operand_loader_if l_if ();

  logic        m_command, l_command, m_op_valid, l_op_valid, m_done, l_done;
  logic [31:0] m_number1, m_number2, l_number1, l_number2;
  logic [3:0]  m_special, l_special;

  fp_operand_loader #(.HOLD_CYCLES(2), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rstn(rstn), .clear(clear), .in_if(m_if),
    .command(m_command), .number1(m_number1), .number2(m_number2),
    .op_valid(m_op_valid), .done(m_done), .special(m_special)
  );

  fp_operand_loader #(.HOLD_CYCLES(2), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rstn(rstn), .clear(clear), .in_if(l_if),
    .command(l_command), .number1(l_number1), .number2(l_number2),
    .op_valid(l_op_valid), .done(l_done), .special(l_special)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
    logic        exp_cmd;
    logic [3:0]  exp_sp;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) repeat ($urandom_range(0, 3)) tick();
    if (sel) begin l_if.in_data = b; l_if.in_valid = 1'b1; end
    else     begin m_if.in_data = b; m_if.in_valid = 1'b1; end
    n = 0;
    while (!(sel ? l_if.in_ready : m_if.in_ready) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got in_ready=0 expected 1 within 100 cycles");
    end
    tick();
    if (sel) l_if.in_valid = 1'b0;
    else     m_if.in_valid = 1'b0;
  endtask

  task automatic send_word(input bit sel, input logic [31:0] w, input bit gaps);
    for (int i = 0; i < 4; i++) begin
      if (sel) send_byte(sel, w[8*i+:8], gaps);
      else     send_byte(sel, w[8*(3-i)+:8], gaps);
    end
  endtask

  task automatic send_pkt(input bit sel, input logic [7:0] cmd, input logic [31:0] a,
                          input logic [31:0] b, input bit gaps);
    send_byte(sel, cmd, gaps);
    send_word(sel, a, gaps);
    send_word(sel, b, gaps);
  endtask

  initial begin
    vecs[0] = '{8'h00, 32'h3F800000, 32'h40000000, 1'b0, 4'b0000};
    vecs[1] = '{8'h01, 32'hC1200000, 32'h3F000000, 1'b1, 4'b0000};
    vecs[2] = '{8'hFE, 32'h7FC00000, 32'h00000000, 1'b0, 4'b1001};
    vecs[3] = '{8'h03, 32'h7F800000, 32'h00000001, 1'b1, 4'b0110};
    vecs[4] = '{8'h00, 32'h00000000, 32'h80000000, 1'b0, 4'b0001};
    vecs[5] = '{8'h00, 32'h7F800000, 32'hFF800000, 1'b0, 4'b0100};

    rstn = 1'b0; clear = 1'b0;
    m_if.in_valid = 1'b0; m_if.in_data = 8'h00;
    l_if.in_valid = 1'b0; l_if.in_data = 8'h00;
    #3;
    check("rst_in_ready", 32'(m_if.in_ready), 32'd1);
    check("rst_op_valid", 32'(m_op_valid), 32'd0);
    check("rst_done", 32'(m_done), 32'd0);
    check("rst_number1", m_number1, 32'd0);
    check("rst_special", 32'(m_special), 32'd0);
    tick();
    rstn = 1'b1;
    tick();

    // Table vectors: operands, class flags and the hold/done timeline.
    for (int v = 0; v < 6; v++) begin
      send_pkt(1'b0, vecs[v].cmd, vecs[v].a, vecs[v].b, 1'b0);
      check($sformatf("v%0d_number1", v), m_number1, vecs[v].a);
      check($sformatf("v%0d_number2", v), m_number2, vecs[v].b);
      check($sformatf("v%0d_command", v), 32'(m_command), 32'(vecs[v].exp_cmd));
      check($sformatf("v%0d_special", v), 32'(m_special), 32'(vecs[v].exp_sp));
      check($sformatf("v%0d_ov0", v), {m_op_valid, m_done, m_if.in_ready}, 32'b100);
      tick();
      check($sformatf("v%0d_ov1", v), {m_op_valid, m_done, m_if.in_ready}, 32'b100);
      tick();
      check($sformatf("v%0d_done", v), {m_op_valid, m_done, m_if.in_ready}, 32'b010);
      tick();
      check($sformatf("v%0d_idle", v), {m_op_valid, m_done, m_if.in_ready}, 32'b001);
      check($sformatf("v%0d_held", v), m_number1, vecs[v].a);
    end

    // in_valid held through hold/done: byte waits and becomes the next command.
    send_pkt(1'b0, 8'h01, 32'hC1200000, 32'h3F000000, 1'b0);
    m_if.in_data = 8'h00; m_if.in_valid = 1'b1;
    check("hv_ready0", 32'(m_if.in_ready), 32'd0);
    tick();
    check("hv_ready1", 32'(m_if.in_ready), 32'd0);
    tick();
    check("hv_ready2", {m_if.in_ready, m_done}, 32'b01);
    tick();
    check("hv_ready3", 32'(m_if.in_ready), 32'd1);
    tick();
    m_if.in_valid = 1'b0;
    check("hv_hold_n1", m_number1, 32'hC1200000);
    check("hv_hold_cmd", 32'(m_command), 32'd1);
    send_word(1'b0, 32'h3F800000, 1'b0);
    send_word(1'b0, 32'h40000000, 1'b0);
    check("hv_new_cmd", 32'(m_command), 32'd0);
    check("hv_new_n1", m_number1, 32'h3F800000);
    check("hv_new_n2", m_number2, 32'h40000000);
    repeat (3) tick();

    // Clear after two bytes of number1, then a complete fresh packet.
    send_byte(1'b0, 8'h01, 1'b0);
    send_byte(1'b0, 8'hAA, 1'b0);
    send_byte(1'b0, 8'hBB, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_n1_kept", m_number1, 32'h3F800000);
    check("clr_ov", 32'(m_op_valid), 32'd0);
    send_byte(1'b0, 8'h00, 1'b0);
    send_word(1'b0, 32'h40400000, 1'b0);
    send_word(1'b0, 32'h3F800000, 1'b0);
    check("clr_new_n1", m_number1, 32'h40400000);
    check("clr_new_n2", m_number2, 32'h3F800000);
    check("clr_new_cmd", 32'(m_command), 32'd0);
    repeat (3) tick();

    // Clear coinciding with the completing byte wins.
    send_byte(1'b0, 8'h01, 1'b0);
    send_word(1'b0, 32'h11111111, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(1'b0, 8'h22, 1'b0);
    m_if.in_data = 8'h22; m_if.in_valid = 1'b1; clear = 1'b1;
    tick();
    m_if.in_valid = 1'b0; clear = 1'b0;
    check("clrpri_ov", 32'(m_op_valid), 32'd0);
    check("clrpri_n1", m_number1, 32'h40400000);
    check("clrpri_ready", 32'(m_if.in_ready), 32'd1);
    tick();
    check("clrpri_done", 32'(m_done), 32'd0);

    // LSB-first instance with random gaps.
    send_pkt(1'b1, 8'h00, 32'h3F800000, 32'h40000000, 1'b1);
    check("lsb_n1", l_number1, 32'h3F800000);
    check("lsb_n2", l_number2, 32'h40000000);
    check("lsb_ov", 32'(l_op_valid), 32'd1);
    repeat (3) tick();
    send_pkt(1'b1, 8'h01, 32'hC1200000, 32'h7FC00000, 1'b1);
    check("lsb2_n1", l_number1, 32'hC1200000);
    check("lsb2_cmd", 32'(l_command), 32'd1);
    check("lsb2_special", 32'(l_special), 32'b1000);
    repeat (3) tick();

    // Asynchronous reset during the hold window.
    send_pkt(1'b0, 8'h00, 32'h3F800000, 32'h40000000, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    check("arst_ov", 32'(m_op_valid), 32'd0);
    check("arst_done", 32'(m_done), 32'd0);
    check("arst_n1", m_number1, 32'd0);
    check("arst_n2", m_number2, 32'd0);
    check("arst_ready", 32'(m_if.in_ready), 32'd1);
    tick();
    rstn = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
